// File: rtl/lane_collision_ctrl.sv
// lane_collision_ctrl: game FSM that detects mario/goomba overlap, tracks lives and score, and pulses lane preset/clear.
module lane_collision_ctrl #(
  parameter int N       = 5,
  parameter int LIVES   = 3,
  parameter int SW      = 8,
  parameter int HIT_CYC = 4
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          start,
  input  logic          step,
  input  logic          jump,
  input  logic [N-1:0]  mario_q,
  input  logic [N-1:0]  goomba_q,
  output logic          lane_preset,
  output logic          lane_clr,
  output logic          running,
  output logic          hit_flash,
  output logic          game_over,
  output logic [2:0]    lives,
  output logic [SW-1:0] score
);
  localparam int HW = $clog2(HIT_CYC + 1);
  typedef enum logic [1:0] {IDLE, RUN, HIT, OVER} state_t;
  state_t state;
  logic [HW-1:0] hcnt;
  logic coll, pass, bump;
  assign coll = step & |(mario_q & goomba_q) & ~jump;
  assign pass = step & goomba_q[N-1] & ~coll;
  assign bump = pass & (score != '1);
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state       <= IDLE;
      lives       <= '0;
      score       <= '0;
      hcnt        <= '0;
      lane_preset <= 1'b0;
      lane_clr    <= 1'b0;
      running     <= 1'b0;
      hit_flash   <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      lane_preset <= 1'b0;
      lane_clr    <= 1'b0;
      case (state)
        IDLE, OVER: if (start) begin
          state       <= RUN;
          lives       <= 3'(LIVES);
          score       <= '0;
          lane_preset <= 1'b1;
          running     <= 1'b1;
          game_over   <= 1'b0;
        end
        RUN: if (coll) begin
          lives <= lives - 3'd1;
          if (lives == 3'd1) begin
            state     <= OVER;
            lane_clr  <= 1'b1;
            running   <= 1'b0;
            game_over <= 1'b1;
          end else begin
            state     <= HIT;
            hcnt      <= HW'(HIT_CYC);
            hit_flash <= 1'b1;
          end
        end else if (bump) score <= score + SW'(1);
        HIT: begin
          if (bump) score <= score + SW'(1);
          // invulnerable window counts game steps, not clock cycles
          if (step) begin
            hcnt <= hcnt - HW'(1);
            if (hcnt == HW'(1)) begin
              state     <= RUN;
              hit_flash <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lane_collision_ctrl.sv
// tb_lane_collision_ctrl: directed scenarios plus randomized play against a rule-level game model.
module tb_lane_collision_ctrl;
  localparam int N = 5, LIVES = 3, SW = 8, HIT_CYC = 4;
  localparam int MAX = (1 << SW) - 1;
  logic clk = 0, clr_n = 0, start = 0, step = 0, jump = 0;
  logic [N-1:0] mario_q = '0, goomba_q = '0;
  logic lane_preset, lane_clr, running, hit_flash, game_over;
  logic [2:0] lives;
  logic [SW-1:0] score;
  int total = 0, bad = 0;
  int e_mode = 0, e_lives = 0, e_score = 0, e_left = 0;
  bit e_pre = 0, e_clr = 0;

  lane_collision_ctrl #(.N(N), .LIVES(LIVES), .SW(SW), .HIT_CYC(HIT_CYC)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .step(step), .jump(jump),
    .mario_q(mario_q), .goomba_q(goomba_q), .lane_preset(lane_preset), .lane_clr(lane_clr),
    .running(running), .hit_flash(hit_flash), .game_over(game_over), .lives(lives), .score(score));

  always #5 clk = ~clk;

  // model modes: 0 idle, 1 playing, 2 invulnerable, 3 game over
  task automatic tick(input bit s, input bit j, input bit st, input logic [N-1:0] m, input logic [N-1:0] g);
    bit c, p;
    step = s; jump = j; start = st; mario_q = m; goomba_q = g;
    c = s && ((m & g) != 0) && !j;
    p = s && g[N-1] && !c;
    e_pre = 0; e_clr = 0;
    if (!clr_n) begin
      e_mode = 0; e_lives = 0; e_score = 0; e_left = 0;
    end else if (e_mode == 0 || e_mode == 3) begin
      if (st) begin e_mode = 1; e_lives = LIVES; e_score = 0; e_pre = 1; end
    end else if (e_mode == 1) begin
      if (c) begin
        e_lives = e_lives - 1;
        if (e_lives == 0) begin e_mode = 3; e_clr = 1; end
        else begin e_mode = 2; e_left = HIT_CYC; end
      end else if (p && e_score < MAX) e_score = e_score + 1;
    end else begin
      if (p && e_score < MAX) e_score = e_score + 1;
      if (s) begin
        e_left = e_left - 1;
        if (e_left == 0) e_mode = 1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    clr_n = 0;
    tick(0, 0, 1, '0, '0);
    tick(1, 0, 1, 5'b00100, 5'b10100);
    total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_running got=%b want=0", running); end
    total++; if (hit_flash !== 1'b0 || game_over !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", hit_flash, game_over); end
    total++; if (lives !== 3'd0) begin bad++; $display("FAIL reset_lives got=%0d want=0", lives); end
    total++; if (score !== '0) begin bad++; $display("FAIL reset_score got=%0d want=0", score); end
    total++; if (lane_preset !== 1'b0 || lane_clr !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%b%b want=00", lane_preset, lane_clr); end
  endtask

  task automatic test_start();
    clr_n = 1;
    tick(0, 0, 1, '0, '0);
    total++; if (lane_preset !== 1'b1) begin bad++; $display("FAIL start_preset got=%b want=1", lane_preset); end
    total++; if (running !== 1'b1 || lives !== 3'd3 || score !== '0) begin bad++; $display("FAIL start_state got run=%b lives=%0d score=%0d want 1/3/0", running, lives, score); end
    tick(0, 0, 1, '0, '0);
    total++; if (lane_preset !== 1'b0) begin bad++; $display("FAIL start_held_preset got=%b want=0", lane_preset); end
    tick(0, 0, 0, '0, '0);
  endtask

  task automatic test_dodge();
    tick(1, 0, 0, 5'b00001, 5'b10000);
    total++; if (score !== 8'd1) begin bad++; $display("FAIL dodge_score got=%0d want=1", score); end
    tick(0, 0, 0, 5'b00001, 5'b10000);
    total++; if (score !== 8'd1) begin bad++; $display("FAIL dodge_nostep got=%0d want=1", score); end
  endtask

  task automatic test_collision_hit();
    tick(1, 0, 0, 5'b00100, 5'b00100);
    total++; if (lives !== 3'd2 || hit_flash !== 1'b1) begin bad++; $display("FAIL coll_hit got lives=%0d flash=%b want 2/1", lives, hit_flash); end
    tick(1, 0, 0, 5'b00100, 5'b00100);
    total++; if (lives !== 3'd2) begin bad++; $display("FAIL hit_invuln got=%0d want=2", lives); end
    tick(0, 0, 0, '0, '0);
    tick(1, 0, 0, 5'b00001, 5'b00000);
    tick(1, 0, 0, 5'b00001, 5'b10000);
    total++; if (hit_flash !== 1'b1 || score !== 8'd2) begin bad++; $display("FAIL hit_third got flash=%b score=%0d want 1/2", hit_flash, score); end
    tick(1, 0, 0, 5'b00001, 5'b00000);
    total++; if (hit_flash !== 1'b0 || running !== 1'b1) begin bad++; $display("FAIL hit_exit got flash=%b run=%b want 0/1", hit_flash, running); end
  endtask

  task automatic test_jump();
    tick(1, 1, 0, 5'b00100, 5'b00100);
    total++; if (lives !== 3'd2 || score !== 8'd2 || hit_flash !== 1'b0) begin bad++; $display("FAIL jump got lives=%0d score=%0d flash=%b want 2/2/0", lives, score, hit_flash); end
    tick(0, 0, 0, 5'b10000, 5'b10000);
    total++; if (lives !== 3'd2) begin bad++; $display("FAIL nostep_overlap got=%0d want=2", lives); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) tick(1, 0, 0, 5'b00001, 5'b10000);
    total++; if (score !== 8'd255) begin bad++; $display("FAIL saturate got=%0d want=255", score); end
  endtask

  task automatic test_game_over();
    tick(1, 0, 0, 5'b01000, 5'b01000);
    for (int i = 0; i < HIT_CYC; i++) tick(1, 0, 0, 5'b00001, 5'b00000);
    total++; if (lives !== 3'd1 || running !== 1'b1 || hit_flash !== 1'b0) begin bad++; $display("FAIL pre_over got lives=%0d run=%b flash=%b want 1/1/0", lives, running, hit_flash); end
    tick(1, 0, 0, 5'b00010, 5'b00110);
    total++; if (game_over !== 1'b1 || lane_clr !== 1'b1 || lives !== 3'd0 || running !== 1'b0) begin bad++; $display("FAIL over got go=%b clr=%b lives=%0d run=%b want 1/1/0/0", game_over, lane_clr, lives, running); end
    tick(1, 0, 0, 5'b10000, 5'b10000);
    total++; if (lane_clr !== 1'b0 || score !== 8'd255 || game_over !== 1'b1) begin bad++; $display("FAIL over_hold got clr=%b score=%0d go=%b want 0/255/1", lane_clr, score, game_over); end
    tick(0, 0, 1, '0, '0);
    total++; if (running !== 1'b1 || lives !== 3'd3 || score !== '0 || lane_preset !== 1'b1 || game_over !== 1'b0) begin bad++; $display("FAIL restart got run=%b lives=%0d score=%0d pre=%b go=%b want 1/3/0/1/0", running, lives, score, lane_preset, game_over); end
    tick(1, 0, 0, 5'b00100, 5'b00100);
    clr_n = 0;
    tick(0, 0, 0, '0, '0);
    total++; if (running !== 1'b0 || hit_flash !== 1'b0 || lives !== 3'd0) begin bad++; $display("FAIL reset_mid_hit got run=%b flash=%b lives=%0d want 0/0/0", running, hit_flash, lives); end
    clr_n = 1;
  endtask

  task automatic test_random();
    logic [N-1:0] m, g;
    for (int i = 0; i < 3000; i++) begin
      clr_n = ($urandom_range(0, 199) != 0);
      m = ($urandom_range(0, 9) == 0) ? '0 : N'(1) << $urandom_range(0, N - 1);
      g = N'($urandom) & N'($urandom);
      tick($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, m, g);
      total++;
      if (running !== (e_mode == 1 || e_mode == 2) || hit_flash !== (e_mode == 2) || game_over !== (e_mode == 3) ||
          lane_preset !== e_pre || lane_clr !== e_clr || lives !== 3'(e_lives) || score !== SW'(e_score)) begin
        bad++;
        $display("FAIL random_%0d got run=%b flash=%b go=%b pre=%b clr=%b lives=%0d score=%0d want mode=%0d pre=%b clr=%b lives=%0d score=%0d",
                 i, running, hit_flash, game_over, lane_preset, lane_clr, lives, score, e_mode, e_pre, e_clr, e_lives, e_score);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_dodge();
    test_collision_hit();
    test_jump();
    test_saturate();
    test_game_over();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
